udp_cksum_fifo_sched: RTL
=========================

Name: udp_cksum_fifo_sched

Overview:
Store-and-forward sequencer for the 256x32 UDP checksum FIFO (one clock domain, DRM read data valid the cycle after rd_en).
- Accepts a UDP payload frame, writes it into the FIFO and accumulates the 16-bit ones'-complement sum.
- Presents the final UDP checksum to the header builder, then drains the stored payload to the MAC-side stream.
- Sits between the UDP payload source and the frame assembler.

Parameters:
MAX_WORDS, 250, maximum payload beats stored per frame (matches FIFO almost-full threshold)
CNT_W, 8, width of beat counters (must hold MAX_WORDS)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  payload beat valid
s_ready  out  1  payload beat accepted when s_valid&&s_ready
s_data  in  32  payload word, byte 0 in [31:24]
s_keep  in  4  valid bytes, MSB-contiguous; only honoured on s_last
s_last  in  1  final beat of frame
cfg_pseudo_sum  in  16  pre-summed pseudo-header (IPs, proto, UDP length), sampled on first beat
cks_valid  out  1  checksum available
cks_ready  in  1  checksum consumed
cks_data  out  16  UDP checksum
m_valid  out  1  drained payload beat valid
m_ready  in  1  downstream accept
m_data  out  32  payload word (= fifo_rd_data)
m_keep  out  4  4'hF except on last beat (stored s_keep)
m_last  out  1  final drained beat
fifo_wr_en  out  1  FIFO write
fifo_wr_data  out  32  FIFO write data (= s_data)
fifo_full  in  1  FIFO full
fifo_rd_en  out  1  FIFO read
fifo_rd_data  in  32  FIFO read data, valid cycle after fifo_rd_en, held until next read
fifo_empty  in  1  FIFO empty
err_oversize  out  1  one-cycle pulse: frame exceeded MAX_WORDS

Behaviour:
- Reset (async, active-high): state IDLE.
  - All outputs 0: s_ready, cks_valid, m_valid, fifo_wr_en, fifo_rd_en, err_oversize; cks_data 0; m_keep 0.
  - Accumulator and counters cleared.
  - The FIFO is reset by the same rst at top level.
  - Reset mid-frame abandons the frame; nothing partial is emitted.
- States: IDLE, ACCUM, FOLD1, FOLD2, CKSUM, DRAIN.
- IDLE/ACCUM:
  - s_ready = !fifo_full.
  - First accepted beat: acc <= cfg_pseudo_sum + beat sum; go to ACCUM.
  - Each accepted beat with wr_cnt < MAX_WORDS: fifo_wr_en=1; acc += masked hi16 + masked lo16; wr_cnt++.
  - Masking: keep 1100 zeroes [15:0]; keep 1000 zeroes [23:0]; keep 1110 zeroes [7:0].
- Oversize beats (wr_cnt == MAX_WORDS):
  - Accepted and discarded: no write, no sum.
  - err_oversize pulses once per frame.
  - Stored frame ends at beat MAX_WORDS with keep 4'hF.
- Accepted s_last: latch last_keep; go to FOLD1.
  - A single-beat frame (s_last on the first beat) goes IDLE -> FOLD1.
- Accumulator: 32 bits; no overflow possible (max 2*250*0xFFFF + 0xFFFF).
- Folding:
  - FOLD1: acc <= acc[15:0] + acc[31:16].
  - FOLD2: same again.
  - Then cks = ~acc[15:0]; if cks == 0, cks = 16'hFFFF.
- Latency: s_last accepted at edge T -> cks_valid=1 in the cycle after edge T+3 (state CKSUM).
- CKSUM: cks_valid held with stable cks_data until cks_ready; then DRAIN with rd_cnt = wr_cnt.
- DRAIN:
  - fifo_rd_en = (rd_cnt != 0) && (!m_valid || m_ready).
  - m_valid registered from fifo_rd_en; m_data = fifo_rd_data.
  - Full throughput when m_ready is held high.
  - m_last/m_keep asserted on the beat where rd_cnt reached 0.
  - After the last beat is accepted: IDLE.
- s_ready=0 in FOLD1..DRAIN; frames never overlap.
- fifo_empty asserted while rd_cnt>0 is a protocol error: hold state, no read. Simulation assertion only.
- m_valid/m_data/m_last/m_keep stable while m_valid && !m_ready.

Decomposition:
- Shared package udp_pkg: state enum, CKSUM_W=16, FIFO_DW=32, FIFO_AW=8, keep-mask function.
- One sub-module, udp_cksum_acc: masked beat sum, accumulate, two-stage fold, zero->FFFF rule.
- Sequencer FSM and drain logic stay in the top.

Test Plan:
- Single beat 0x12345678, keep F, last, pseudo 0 -> cks_data 0x9753; one m beat 0x12345678, m_last=1, m_keep=F.
- Beats 0xFFFF0001, 0x00000000(last), pseudo 0 -> sum 0x10000 folds to 0x0001 -> cks 0xFFFE; two drained beats in order.
- Beat 0xFFFF0000 last, pseudo 0 -> complement 0 -> cks_data 0xFFFF.
- Beat 0xABCDEEEE, keep 1100, last, pseudo 0 -> cks 0x5432; m_keep 1100 on output.
- 252-beat frame -> 250 FIFO writes, err_oversize one pulse, 250 drained beats, m_last on 250th.
- Random m_ready/cks_ready backpressure plus rst asserted mid-DRAIN -> outputs 0 immediately, IDLE; next frame checksums correctly.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types and helpers for the UDP checksum FIFO sequencer.
package udp_pkg;

  localparam int CKSUM_W = 16;
  localparam int FIFO_DW = 32;
  localparam int FIFO_AW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FOLD1,
    S_FOLD2,
    S_CKSUM,
    S_DRAIN
  } state_t;

  // Byte-enable to bit mask; byte 0 lives in [31:24], keep is MSB-contiguous.
  function automatic logic [FIFO_DW-1:0] keep_mask(input logic [3:0] keep);
    logic [FIFO_DW-1:0] m;
    case (keep)
      4'b1110: m = 32'hFFFF_FF00;
      4'b1100: m = 32'hFFFF_0000;
      4'b1000: m = 32'hFF00_0000;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/udp_cksum_acc.sv
// Ones'-complement accumulator: masked beat sum, accumulate, two folds, final complement.
module udp_cksum_acc
  import udp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               add_en,
  input  logic               first,
  input  logic               fold,
  input  logic [FIFO_DW-1:0] data,
  input  logic [3:0]         keep,
  input  logic               last,
  input  logic [CKSUM_W-1:0] pseudo,
  output logic [CKSUM_W-1:0] cks
);

  logic [FIFO_DW-1:0] masked;
  logic [31:0]        beat_sum;
  logic [31:0]        base;
  logic [31:0]        acc;
  logic [CKSUM_W-1:0] cks_raw;

  // Byte enables only apply to the closing beat of a frame.
  assign masked   = data & (last ? keep_mask(keep) : 32'hFFFF_FFFF);
  assign beat_sum = {16'h0, masked[31:16]} + {16'h0, masked[15:0]};
  assign base     = first ? {16'h0, pseudo} : acc;

  // Accumulate stored beats, or fold the carries back into the low half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= base + beat_sum;
    end else if (fold) begin
      acc <= {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    end
  end

  // A computed checksum of zero is sent as all-ones (zero means "no checksum").
  always_comb begin
    cks_raw = ~acc[15:0];
    cks     = (cks_raw == '0) ? 16'hFFFF : cks_raw;
  end

endmodule

// File: rtl/udp_cksum_fifo_sched.sv
// Store-and-forward sequencer: write payload to FIFO while summing, hand out the
// UDP checksum, then drain the stored payload to the MAC-side stream.
module udp_cksum_fifo_sched
  import udp_pkg::*;
#(
  parameter int MAX_WORDS = 250,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FIFO_DW-1:0] s_data,
  input  logic [3:0]         s_keep,
  input  logic               s_last,
  input  logic [CKSUM_W-1:0] cfg_pseudo_sum,
  output logic               cks_valid,
  input  logic               cks_ready,
  output logic [CKSUM_W-1:0] cks_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FIFO_DW-1:0] m_data,
  output logic [3:0]         m_keep,
  output logic               m_last,
  output logic               fifo_wr_en,
  output logic [FIFO_DW-1:0] fifo_wr_data,
  input  logic               fifo_full,
  output logic               fifo_rd_en,
  input  logic [FIFO_DW-1:0] fifo_rd_data,
  input  logic               fifo_empty,
  output logic               err_oversize
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wr_cnt, wr_idx, rd_cnt;
  logic               accept, acc_first, acc_fold, ovf_seen;
  logic [3:0]         last_keep;
  logic [CKSUM_W-1:0] cks_fold;

  assign accept       = s_valid && s_ready;
  // wr_cnt still holds the previous frame's length while idle.
  assign wr_idx       = (state == S_IDLE) ? '0 : wr_cnt;
  assign fifo_wr_en   = accept && (wr_idx != MAX_CNT);
  assign fifo_wr_data = s_data;
  assign m_data       = fifo_rd_data;
  assign acc_first    = accept && (state == S_IDLE);

  udp_cksum_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .add_en (fifo_wr_en),
    .first  (acc_first),
    .fold   (acc_fold),
    .data   (s_data),
    .keep   (s_keep),
    .last   (s_last),
    .pseudo (cfg_pseudo_sum),
    .cks    (cks_fold)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; frames never overlap.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = s_last ? S_FOLD1 : S_ACCUM;
      S_ACCUM: if (accept && s_last) state_nxt = S_FOLD1;
      S_FOLD1: state_nxt = S_FOLD2;
      S_FOLD2: state_nxt = S_CKSUM;
      S_CKSUM: if (cks_valid && cks_ready) state_nxt = S_DRAIN;
      S_DRAIN: if (m_valid && m_ready && m_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded controls; a dry FIFO while beats are owed stalls the read.
  always_comb begin
    s_ready    = 1'b0;
    fifo_rd_en = 1'b0;
    acc_fold   = 1'b0;
    case (state)
      S_IDLE, S_ACCUM: s_ready = !fifo_full && !rst;
      S_FOLD1, S_FOLD2: acc_fold = 1'b1;
      S_DRAIN: fifo_rd_en = (rd_cnt != '0) && (!m_valid || m_ready) && !fifo_empty;
      default: ;
    endcase
  end

  // Write-side bookkeeping: beat count, overflow flag, closing keep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt       <= '0;
      ovf_seen     <= 1'b0;
      err_oversize <= 1'b0;
      last_keep    <= '0;
    end else begin
      err_oversize <= 1'b0;
      if (accept) begin
        if (fifo_wr_en) begin
          wr_cnt <= wr_idx + 1'b1;
        end else begin
          if (!ovf_seen) err_oversize <= 1'b1;
          ovf_seen <= 1'b1;
        end
        if (state == S_IDLE) ovf_seen <= 1'b0;
        if (s_last) last_keep <= fifo_wr_en ? s_keep : 4'hF;
      end
    end
  end

  // Checksum handoff: capture the folded result once, hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cks_valid <= 1'b0;
      cks_data  <= '0;
    end else if (state == S_CKSUM) begin
      if (!cks_valid) begin
        cks_valid <= 1'b1;
        cks_data  <= cks_fold;
      end else if (cks_ready) begin
        cks_valid <= 1'b0;
      end
    end
  end

  // Drain side: output beat registered alongside the FIFO read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_keep  <= '0;
    end else begin
      if (state == S_CKSUM && cks_valid && cks_ready) rd_cnt <= wr_cnt;
      if (fifo_rd_en) begin
        rd_cnt  <= rd_cnt - 1'b1;
        m_valid <= 1'b1;
        m_last  <= (rd_cnt == CNT_W'(1));
        m_keep  <= (rd_cnt == CNT_W'(1)) ? last_keep : 4'hF;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        m_keep  <= '0;
      end
    end
  end

  // The FIFO running dry while stored beats are still owed means lost data upstream.
  assert property (@(posedge clk) disable iff (rst)
    !(state == S_DRAIN && rd_cnt != '0 && fifo_empty));

endmodule
